// File: rtl/bcd_up_down_counter_if.sv
// Bus for one BCD up/down counter digit: load/count controls in, count and
// cascade strobes out. Clock and clear stay on the module as plain ports.
interface bcd_up_down_counter_if;
   logic       load;
   logic [3:0] d;
   logic       en;
   logic       up;
   logic [3:0] q;
   logic       co;
   logic       bo;

   modport master (output load, d, en, up, input q, co, bo);
   modport slave  (input load, d, en, up, output q, co, bo);
endinterface

// File: rtl/bcd_up_down_counter.sv
// Modulo-N up/down counter digit with parallel load and combinational
// carry/borrow for zero-latency synchronous cascading.
// Priority per edge: clr > load > count > hold.
// Optional macro BCD_CNT_LOAD_CLAMP_EN clamps loaded values above MODULUS-1
// down to MODULUS-1; without it the raw value is loaded and out-of-range
// states recover on the next count (up -> 0, down -> MODULUS-1).
// DELAY is a simulation-only output delay; this RTL is zero-delay.
module bcd_up_down_counter #(
   parameter int DELAY   = 10,
   parameter int MODULUS = 10
) (
   input logic                    clk,
   input logic                    clr,
   bcd_up_down_counter_if.slave   bus
);

   localparam logic [3:0] LAST = 4'(MODULUS - 1);

   generate
      if (MODULUS < 2 || MODULUS > 16 || DELAY < 0) begin : g_param_check
         $error("bcd_up_down_counter: MODULUS must be 2..16 and DELAY >= 0");
      end
   endgenerate

   logic [3:0] count_q;
   logic [3:0] count_nxt;
   logic [3:0] load_val;
   logic       at_last;
   logic       at_zero;
   logic       out_of_range;

   // Compare against LAST rather than MODULUS so MODULUS=16 stays in 4 bits.
   assign at_last      = (count_q == LAST);
   assign at_zero      = (count_q == 4'd0);
   assign out_of_range = (count_q > LAST);

   // Value taken on a load strobe.
   always_comb begin
      load_val = bus.d;
`ifdef BCD_CNT_LOAD_CLAMP_EN
      if (bus.d > LAST) begin
         load_val = LAST;
      end
`endif
   end

   // Next count in the selected direction, wrapping and recovering out-of-range.
   always_comb begin
      count_nxt = count_q;
      if (bus.up) begin
         if (at_last || out_of_range) begin
            count_nxt = 4'd0;
         end else begin
            count_nxt = count_q + 4'd1;
         end
      end else begin
         if (at_zero || out_of_range) begin
            count_nxt = LAST;
         end else begin
            count_nxt = count_q - 4'd1;
         end
      end
   end

   // Count register with clr > load > count > hold priority.
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= 4'd0;
      end else if (bus.load) begin
         count_q <= load_val;
      end else if (bus.en) begin
         count_q <= count_nxt;
      end
   end

   assign bus.q  = count_q;
   assign bus.co = bus.en &  bus.up & at_last;
   assign bus.bo = bus.en & ~bus.up & at_zero;

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Directed bench: MODULUS=10 digit, MODULUS=6 digit and a two-digit cascade.
module tb_bcd_up_down_counter;

   logic clk = 1'b0;
   logic clr_a, clr_b, clr_c;
   int   passed = 0;
   int   total  = 0;

   typedef struct {
      string      tag;
      logic [3:0] q;
   } exp_t;
   exp_t sb[$];

   logic [3:0] mq_a = 4'bx;
   logic [3:0] mq_b = 4'bx;

   bcd_up_down_counter_if ifc_a ();
   bcd_up_down_counter_if ifc_b ();
   bcd_up_down_counter_if ifc_u ();
   bcd_up_down_counter_if ifc_t ();

   bcd_up_down_counter #(.DELAY(10), .MODULUS(10)) dut_a (.clk(clk), .clr(clr_a), .bus(ifc_a));
   bcd_up_down_counter #(.DELAY(10), .MODULUS(6))  dut_b (.clk(clk), .clr(clr_b), .bus(ifc_b));
   bcd_up_down_counter #(.DELAY(10), .MODULUS(10)) dut_u (.clk(clk), .clr(clr_c), .bus(ifc_u));
   bcd_up_down_counter #(.DELAY(10), .MODULUS(10)) dut_t (.clk(clk), .clr(clr_c), .bus(ifc_t));

   assign ifc_t.en = ifc_u.co;

   always #5 clk = ~clk;

   function automatic logic [3:0] model(input logic [3:0] q, input logic c, input logic l,
                                        input logic [3:0] dv, input logic e, input logic u,
                                        input int m);
      logic [3:0] r;
      r = q;
      if (c) r = 4'd0;
      else if (l) begin
         r = dv;
`ifdef BCD_CNT_LOAD_CLAMP_EN
         if (int'(dv) >= m) r = 4'(m - 1);
`endif
      end else if (e) begin
         if (u) r = (int'(q) >= m - 1) ? 4'd0 : q + 4'd1;
         else   r = (q == 4'd0 || int'(q) >= m) ? 4'(m - 1) : q - 4'd1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step(input int sel, input string tag, input logic c, input logic l,
                       input logic [3:0] dv, input logic e, input logic u);
      logic [3:0] cur;
      logic       co_o, bo_o;
      int         m;
      exp_t       item;
      @(negedge clk);
      if (sel == 0) begin
         clr_a = c; ifc_a.load = l; ifc_a.d = dv; ifc_a.en = e; ifc_a.up = u;
         cur = mq_a; m = 10;
      end else begin
         clr_b = c; ifc_b.load = l; ifc_b.d = dv; ifc_b.en = e; ifc_b.up = u;
         cur = mq_b; m = 6;
      end
      #1;
      co_o = (sel == 0) ? ifc_a.co : ifc_b.co;
      bo_o = (sel == 0) ? ifc_a.bo : ifc_b.bo;
      if (!$isunknown(cur)) begin
         chk({tag, "_co"}, {3'b0, co_o}, {3'b0, e & u & (int'(cur) == m - 1)});
         chk({tag, "_bo"}, {3'b0, bo_o}, {3'b0, e & ~u & (cur == 4'd0)});
      end
      item.tag = tag;
      item.q   = model(cur, c, l, dv, e, u, m);
      sb.push_back(item);
      if (sel == 0) mq_a = item.q; else mq_b = item.q;
      @(posedge clk);
      #1;
      item = sb.pop_front();
      chk({item.tag, "_q"}, (sel == 0) ? ifc_a.q : ifc_b.q, item.q);
   endtask

   initial begin
      ifc_u.load = 1'b0; ifc_u.d = 4'd0; ifc_u.en = 1'b0; ifc_u.up = 1'b1;
      ifc_t.load = 1'b0; ifc_t.d = 4'd0; ifc_t.up = 1'b1;
      clr_c = 1'b0;

      // MODULUS=10 digit
      step(0, "rst", 1, 1, 4'd7, 1, 1);
      for (int i = 0; i < 10; i++) step(0, "up", 0, 0, 4'd0, 1, 1);
      step(0, "up_after", 0, 0, 4'd0, 1, 1);
      step(0, "hold", 0, 0, 4'd0, 0, 1);
      step(0, "ld5", 0, 1, 4'd5, 0, 0);
      step(0, "ld_en", 0, 1, 4'd3, 1, 1);
      for (int i = 0; i < 3; i++) step(0, "dn", 0, 0, 4'd0, 1, 0);
      step(0, "dn_wrap", 0, 0, 4'd0, 1, 0);
      step(0, "dir_up", 0, 0, 4'd0, 1, 1);
      step(0, "dir_dn", 0, 0, 4'd0, 1, 0);
      step(0, "ld12", 0, 1, 4'd12, 0, 1);
      step(0, "oor_up", 0, 0, 4'd0, 1, 1);
      step(0, "ld14", 0, 1, 4'd14, 0, 0);
      step(0, "oor_dn", 0, 0, 4'd0, 1, 0);
      step(0, "ld2", 0, 1, 4'd2, 0, 1);
      step(0, "mid", 0, 0, 4'd0, 1, 1);
      step(0, "clr_mid", 1, 0, 4'd0, 1, 0);
      step(0, "resume", 0, 0, 4'd0, 1, 0);

      // MODULUS=6 digit
      step(1, "b_rst", 1, 0, 4'd0, 0, 0);
      step(1, "b_dn_wrap", 0, 0, 4'd0, 1, 0);
      step(1, "b_dn", 0, 0, 4'd0, 1, 0);
      step(1, "b_ld5", 0, 1, 4'd5, 0, 1);
      step(1, "b_up_wrap", 0, 0, 4'd0, 1, 1);

      // Two-digit cascade: tens enabled by units carry
      @(negedge clk);
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
      ifc_u.en = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      chk("casc_units9", ifc_u.q, 4'd9);
      chk("casc_tens_en", {3'b0, ifc_t.en}, 4'd1);
      chk("casc_tens0", ifc_t.q, 4'd0);
      @(posedge clk);
      #1;
      chk("casc_units10", ifc_u.q, 4'd0);
      chk("casc_tens10", ifc_t.q, 4'd1);
      repeat (50) @(posedge clk);
      #1;
      ifc_u.en = 1'b0;
      chk("casc_units60", ifc_u.q, 4'd0);
      chk("casc_tens60", ifc_t.q, 4'd6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
